instr_fetch: RTL and testbench

Instruction fetch unit between the core's decode stage and the instruction port of the boot ROM. Maintains the fetch PC and issues word reads on the ROM's instruction request/grant port. Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Handles redirects (branches, jumps, traps) by flushing buffered and in-flight fetches.

---
 rtl/ifu_pkg.sv | 30 +++
 rtl/ifu_fifo.sv | 73 +++++++
 rtl/instr_fetch.sv | 179 +++++++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared types and constants for the instruction fetch unit.
//   ifu_state_e     : fetch FSM states
//   ifu_entry_t     : one buffered fetch {pc, instr}
//   IFU_RESET_PC    : default first fetch address after reset
//   is_word_aligned : helper used by the optional misaligned-redirect check
// ---------------------------------------------------------------------------
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifu_entry_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Small synchronous FIFO holding fetched {pc, instr} entries for decode.
// Parameters:
//   DEPTH       : number of entries, power of two, >= 2
// Ports:
//   i_CLK       : clock
//   i_RSTn      : synchronous active-low reset; clears pointers, count, storage
//   i_PUSH      : write i_PUSH_DATA at the tail
//   i_PUSH_DATA : entry to write
//   i_POP       : drop the head entry
//   i_FLUSH     : empty the FIFO (wins over push/pop)
//   o_COUNT     : number of valid entries
//   o_HEAD      : head entry (meaningful only when o_COUNT != 0)
// The caller guarantees no push when full (unless popping) and no pop when
// empty.
// ---------------------------------------------------------------------------
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_CLK,
  input  logic                     i_RSTn,
  input  logic                     i_PUSH,
  input  ifu_entry_t               i_PUSH_DATA,
  input  logic                     i_POP,
  input  logic                     i_FLUSH,
  output logic [$clog2(DEPTH):0]   o_COUNT,
  output ifu_entry_t               o_HEAD
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ifu_entry_t      r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      // Storage is cleared so the head reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_PUSH) begin
        r_mem[r_wr_ptr] <= i_PUSH_DATA;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_POP) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({i_PUSH, i_POP})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_COUNT = r_count;
  assign o_HEAD  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit between decode and the boot ROM instruction port.
// Keeps the fetch PC, issues one outstanding word read at a time, buffers
// returned words with their PCs and hands them to decode. Redirects flush
// everything buffered or in flight.
// Optional feature macro: IFU_ALIGN_CHECK_EN -- misaligned redirect targets
// raise a sticky o_FETCH_FAULT and park the unit in HALT until an aligned
// redirect arrives. Without it, the low two target bits are forced to zero.
// Parameters:
//   RESET_PC, FIFO_DEPTH (power of two, >= 2)
// Ports:
//   i_CLK, i_RSTn      : clock, synchronous active-low reset
//   o_INSTR_REQ        : read request to ROM (registered)
//   o_ADDR_INSTR       : word-aligned fetch address (registered)
//   i_INSTR_GNT        : ROM grant, i_RDATA_INSTR valid this cycle
//   i_RDATA_INSTR      : ROM word
//   o_INSTR_VALID      : head valid for decode
//   o_INSTR, o_PC      : head word and its PC
//   i_INSTR_READY      : decode accepts the head
//   i_REDIRECT         : one-cycle redirect strobe
//   i_REDIRECT_PC      : redirect target
//   o_FETCH_FAULT      : sticky misaligned-redirect fault
//   o_DBG_STATE        : current FSM state, for observation only
//
// Decode handshake: the head transfers on a cycle where o_INSTR_VALID and
// i_INSTR_READY are both high; while o_INSTR_VALID is high and no transfer
// happens, o_INSTR/o_PC hold. o_INSTR_VALID is forced low during a redirect
// so a stale entry can never transfer in the cycle it is being flushed.
// ---------------------------------------------------------------------------
module instr_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  output logic        o_INSTR_REQ,
  output logic [31:0] o_ADDR_INSTR,
  input  logic        i_INSTR_GNT,
  input  logic [31:0] i_RDATA_INSTR,
  output logic        o_INSTR_VALID,
  output logic [31:0] o_INSTR,
  output logic [31:0] o_PC,
  input  logic        i_INSTR_READY,
  input  logic        i_REDIRECT,
  input  logic [31:0] i_REDIRECT_PC,
  output logic        o_FETCH_FAULT,
  output ifu_state_e  o_DBG_STATE
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  ifu_state_e    r_state;
  logic          r_req;
  logic [31:0]   r_fetch_pc;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_after_push;
  ifu_entry_t    w_head;
  ifu_entry_t    w_push_data;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [31:0]   w_redirect_pc;

  // A grant only counts while actively fetching; grants landing in FLUSH,
  // HALT or alongside a redirect belong to an abandoned fetch.
  assign w_push      = (r_state == FETCH) & i_INSTR_GNT & ~i_REDIRECT;
  assign w_valid     = (w_count != '0) & ~i_REDIRECT;
  assign w_pop       = w_valid & i_INSTR_READY;
  assign w_push_data = '{pc: r_fetch_pc, instr: i_RDATA_INSTR};

  // Occupancy once this cycle's grant and any same-cycle pop have settled.
  assign w_cnt_after_push = w_count + CW'(1) - CW'(w_pop);

`ifdef IFU_ALIGN_CHECK_EN
  logic r_fault;

  assign w_redirect_pc = i_REDIRECT_PC;

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      r_fault <= 1'b0;
    end else if (i_REDIRECT) begin
      r_fault <= ~is_word_aligned(i_REDIRECT_PC);
    end
  end

  assign o_FETCH_FAULT = r_fault;
`else
  logic w_unused_redirect_lsbs;

  assign w_unused_redirect_lsbs = ^i_REDIRECT_PC[1:0];
  assign w_redirect_pc          = {i_REDIRECT_PC[31:2], 2'b00};
  assign o_FETCH_FAULT          = 1'b0;
`endif

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_fetch_pc <= RESET_PC;
    end else if (i_REDIRECT) begin
      r_fetch_pc <= w_redirect_pc;
      r_req      <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      r_state    <= is_word_aligned(i_REDIRECT_PC) ? FLUSH : HALT;
`else
      r_state    <= FLUSH;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
        end
        FETCH: begin
          // Request stays high through the grant cycle; the ROM's no
          // back-to-back-grant rule makes that the next fetch's request.
          if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_cnt_after_push < DEPTH_C) begin
              r_state <= FETCH;
              r_req   <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_req   <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (w_count < DEPTH_C) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
          end
        end
        FLUSH: begin
          // One quiet cycle absorbs a grant for the pre-redirect request.
          r_state <= FETCH;
          r_req   <= 1'b1;
        end
`ifdef IFU_ALIGN_CHECK_EN
        HALT: begin
          r_state <= HALT;
          r_req   <= 1'b0;
        end
`endif
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_CLK       (i_CLK),
    .i_RSTn      (i_RSTn),
    .i_PUSH      (w_push),
    .i_PUSH_DATA (w_push_data),
    .i_POP       (w_pop),
    .i_FLUSH     (i_REDIRECT),
    .o_COUNT     (w_count),
    .o_HEAD      (w_head)
  );

  assign o_INSTR_REQ   = r_req;
  assign o_ADDR_INSTR  = r_fetch_pc;
  assign o_INSTR_VALID = w_valid;
  assign o_INSTR       = w_head.instr;
  assign o_PC          = w_head.pc;
  assign o_DBG_STATE   = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. A behavioural ROM grants one cycle after
// seeing a request and never on consecutive cycles. Outputs are sampled on
// the falling edge; inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ready;
  logic        redir;
  logic [31:0] redir_pc;
  logic        fault;
  ifu_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch dut (
    .i_CLK         (clk),
    .i_RSTn        (rstn),
    .o_INSTR_REQ   (req),
    .o_ADDR_INSTR  (addr),
    .i_INSTR_GNT   (gnt),
    .i_RDATA_INSTR (rdata),
    .o_INSTR_VALID (valid),
    .o_INSTR       (instr),
    .o_PC          (pc),
    .i_INSTR_READY (ready),
    .i_REDIRECT    (redir),
    .i_REDIRECT_PC (redir_pc),
    .o_FETCH_FAULT (fault),
    .o_DBG_STATE   (dbg_state)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0093;
      32'h0000_0004: return 32'h0010_0113;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // ROM: grant the cycle after a sampled request, never back to back.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      gnt   <= 1'b0;
      rdata <= '0;
    end else if (req && !gnt) begin
      gnt   <= 1'b1;
      rdata <= rom_word(addr);
    end else begin
      gnt   <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rstn     = 1'b0;
    redir    = 1'b0;
    redir_pc = '0;
    repeat (3) cyc();
    check({tag, "_req"},   32'(req),   32'd0);
    check({tag, "_addr"},  addr,       32'h0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_instr"}, instr,      32'h0);
    check({tag, "_pc"},    pc,         32'h0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    rstn = 1'b1;
  endtask

  task automatic redirect_pulse(input string tag, input logic [31:0] target);
    redir_pc = target;
    redir    = 1'b1;
    #1;
    check({tag, "_valid_low"}, 32'(valid), 32'd0);
    cyc();
    redir = 1'b0;
  endtask

  task automatic wait_deliver(input string tag, input logic [31:0] exp_pc);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (valid && ready) begin
        got = 1'b1;
        check({tag, "_pc"},    pc,    exp_pc);
        check({tag, "_instr"}, instr, rom_word(exp_pc));
      end
      cyc();
    end
    check({tag, "_delivered"}, 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    ready    = 1'b1;
    redir    = 1'b0;
    redir_pc = '0;
    rstn     = 1'b0;

    // Reset and first-fetch latency.
    do_reset("t1_rst");
    cyc();
    check("t1_c1_req",   32'(req),       32'd1);
    check("t1_c1_addr",  addr,           32'h0);
    check("t1_c1_state", 32'(dbg_state), 32'(FETCH));
    check("t1_c1_valid", 32'(valid),     32'd0);
    cyc();
    check("t1_c2_valid", 32'(valid),     32'd0);
    cyc();
    check("t1_c3_valid", 32'(valid),     32'd1);
    check("t1_c3_pc",    pc,             32'h0);
    check("t1_c3_instr", instr,          32'h0000_0093);
    cyc();
    check("t1_c4_valid", 32'(valid),     32'd0);
    check("t1_c4_addr",  addr,           32'h4);
    cyc();
    check("t1_c5_valid", 32'(valid),     32'd1);
    check("t1_c5_pc",    pc,             32'h4);
    check("t1_c5_instr", instr,          32'h0010_0113);

    // Redirect in the same cycle as a grant.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      found = gnt;
    end
    check("t3_gnt_seen", 32'(found), 32'd1);
    redirect_pulse("t3", 32'h0000_0100);
    check("t3_t1_state", 32'(dbg_state), 32'(FLUSH));
    check("t3_t1_req",   32'(req),       32'd0);
    check("t3_t1_valid", 32'(valid),     32'd0);
    cyc();
    check("t3_t2_req",   32'(req),       32'd1);
    check("t3_t2_addr",  addr,           32'h0000_0100);
    cyc();
    check("t3_t3_valid", 32'(valid),     32'd0);
    cyc();
    check("t3_t4_valid", 32'(valid),     32'd1);
    check("t3_t4_pc",    pc,             32'h0000_0100);
    check("t3_t4_instr", instr,          32'hC0DE_0100);

    // Back-pressure fills the FIFO, then drains in order.
    ready = 1'b0;
    do_reset("t2_rst");
    repeat (20) cyc();
    check("t2_full_req",   32'(req),       32'd0);
    check("t2_full_valid", 32'(valid),     32'd1);
    check("t2_full_pc",    pc,             32'h0);
    check("t2_full_addr",  addr,           32'h8);
    check("t2_full_state", 32'(dbg_state), 32'(WAIT));
    ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    while (exp_q.size() != 0) begin
      wait_deliver("t2_drain", exp_q.pop_front());
    end

    // Redirect while a request is pending; stale grant lands in FLUSH.
    // Target also exercises PC wrap.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      found = req && !gnt;
      if (!found) cyc();
    end
    check("t5_req_pending", 32'(found), 32'd1);
    redirect_pulse("t5", 32'hFFFF_FFFC);
    wait_deliver("t5_top", 32'hFFFF_FFFC);
    wait_deliver("t5_wrap", 32'h0000_0000);

    // Redirect with full FIFO while the head is being accepted.
    ready = 1'b0;
    do_reset("t4_rst");
    repeat (12) cyc();
    check("t4_full_valid", 32'(valid), 32'd1);
    check("t4_full_pc",    pc,         32'h0);
    ready = 1'b1;
    redirect_pulse("t4", 32'h0000_0040);
    wait_deliver("t4_first",  32'h0000_0040);
    wait_deliver("t4_second", 32'h0000_0044);

    // Misaligned redirect target.
`ifdef IFU_ALIGN_CHECK_EN
    redirect_pulse("t6_bad", 32'h0000_0102);
    check("t6_fault_set", 32'(fault),     32'd1);
    check("t6_halt",      32'(dbg_state), 32'(HALT));
    repeat (5) cyc();
    check("t6_halt_req",   32'(req),   32'd0);
    check("t6_halt_valid", 32'(valid), 32'd0);
    redirect_pulse("t6_bad2", 32'h0000_0106);
    check("t6_fault_kept", 32'(fault), 32'd1);
    redirect_pulse("t6_good", 32'h0000_0200);
    check("t6_fault_clr", 32'(fault),     32'd0);
    check("t6_flush",     32'(dbg_state), 32'(FLUSH));
    cyc();
    check("t6_req",  32'(req), 32'd1);
    check("t6_addr", addr,     32'h0000_0200);
    wait_deliver("t6_resume", 32'h0000_0200);
`else
    redirect_pulse("t6_bad", 32'h0000_0102);
    check("t6_fault_tied", 32'(fault),     32'd0);
    check("t6_flush",      32'(dbg_state), 32'(FLUSH));
    cyc();
    check("t6_addr_forced", addr, 32'h0000_0100);
    wait_deliver("t6_resume", 32'h0000_0100);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
